// File: rtl/fq_pkg.sv
// Shared types and sizing helpers for the dual-issue fetch queue.
// Default entry layout and geometry; the top re-declares the entry with its own IW/AW.
package fq_pkg;

  localparam int FQ_DEPTH = 8;
  localparam int FQ_IW    = 32;
  localparam int FQ_AW    = 32;

  typedef struct packed {
    logic [FQ_IW-1:0] inst;
    logic [FQ_AW-1:0] pc;
  } fq_entry_t;

  function automatic int fq_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int fq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fq_regfile.sv
// Entry storage for fetch_queue: two adjacent write ports, two adjacent async read ports.
// Data is never reset; validity is tracked by the owner's count.
module fq_regfile
  import fq_pkg::*;
#(
  parameter int  DEPTH   = FQ_DEPTH,
  parameter type entry_t = fq_entry_t,
  localparam int PW      = fq_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we0,
  input  logic          we1,
  input  logic [PW-1:0] wa,
  input  entry_t        wd0,
  input  entry_t        wd1,
  input  logic [PW-1:0] ra,
  output entry_t        rd0,
  output entry_t        rd1
);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wa1;
  logic [PW-1:0] ra1;

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign wa1 = wa + PW'(1);
  assign ra1 = ra + PW'(1);

  always_ff @(posedge clk) begin
    if (we0) mem[wa]  <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  assign rd0 = mem[ra];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue feeding IF/ID: push 0-2, present oldest two, retire 0-2.
// Define FQ_STATS_EN to build the saturating stall_cycles counter; otherwise it reads 0.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int IW    = FQ_IW,
  parameter int AW    = FQ_AW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       hold,
  input  logic [1:0]                 in_valid,
  input  logic [IW-1:0]              in_inst0,
  input  logic [AW-1:0]              in_pc0,
  input  logic [IW-1:0]              in_inst1,
  input  logic [AW-1:0]              in_pc1,
  output logic                       in_ready,
  input  logic [1:0]                 issue_cnt,
  output logic                       out_valid0,
  output logic [IW-1:0]              out_inst0,
  output logic [AW-1:0]              out_pc0,
  output logic                       out_valid1,
  output logic [IW-1:0]              out_inst1,
  output logic [AW-1:0]              out_pc1,
  output logic [fq_cnt_w(DEPTH)-1:0] count,
  output logic [31:0]                stall_cycles
);

  localparam int PW = fq_ptr_w(DEPTH);
  localparam int CW = fq_cnt_w(DEPTH);

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AW-1:0] pc;
  } entry_t;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic [1:0]    issue_eff;
  entry_t        wd0, wd1, rd0, rd1;

  // Handshake: a fetch pair transfers on a clock edge where in_ready=1 (and no flush);
  // in_ready depends only on registered count, so fetch must hold data while it is low.
  assign in_ready = (cnt <= CW'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    if (in_ready && !flush) begin
      case (in_valid)
        2'b11:   push_n = 2'd2;
        2'b01:   push_n = 2'd1;
        default: push_n = 2'd0;
      endcase
    end
  end

  assign issue_eff = (issue_cnt == 2'd3) ? 2'd2 : issue_cnt;

  always_comb begin
    pop_n = 2'd0;
    if (!hold) begin
      if (CW'(issue_eff) > cnt) pop_n = cnt[1:0];
      else                      pop_n = issue_eff;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      cnt    <= cnt + CW'(push_n) - CW'(pop_n);
    end
  end

  assign wd0 = '{inst: in_inst0, pc: in_pc0};
  assign wd1 = '{inst: in_inst1, pc: in_pc1};

  fq_regfile #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_regfile (
    .clk (clk),
    .we0 (push_n != 2'd0),
    .we1 (push_n == 2'd2),
    .wa  (wr_ptr),
    .wd0 (wd0),
    .wd1 (wd1),
    .ra  (rd_ptr),
    .rd0 (rd0),
    .rd1 (rd1)
  );

  assign out_valid0 = (cnt >= CW'(1));
  assign out_valid1 = (cnt >= CW'(2));
  assign out_inst0  = rd0.inst;
  assign out_pc0    = rd0.pc;
  assign out_inst1  = rd1.inst;
  assign out_pc1    = rd1.pc;
  assign count      = cnt;

`ifdef FQ_STATS_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((in_valid != 2'b00) && !in_ready && !flush && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=8): reset, push, full, hold, flush, wrap, async reset.
// Expected PCs for the wrap scenario come from a bench-side queue of pushed PCs.
module tb_fetch_queue;

  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        hold;
  logic [1:0]  in_valid;
  logic [31:0] in_inst0, in_pc0, in_inst1, in_pc1;
  logic        in_ready;
  logic [1:0]  issue_cnt;
  logic        out_valid0, out_valid1;
  logic [31:0] out_inst0, out_pc0, out_inst1, out_pc1;
  logic [3:0]  count;
  logic [31:0] stall_cycles;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  fetch_queue dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .hold         (hold),
    .in_valid     (in_valid),
    .in_inst0     (in_inst0),
    .in_pc0       (in_pc0),
    .in_inst1     (in_inst1),
    .in_pc1       (in_pc1),
    .in_ready     (in_ready),
    .issue_cnt    (issue_cnt),
    .out_valid0   (out_valid0),
    .out_inst0    (out_inst0),
    .out_pc0      (out_pc0),
    .out_valid1   (out_valid1),
    .out_inst1    (out_inst1),
    .out_pc1      (out_pc1),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    flush     = 1'b0;
    hold      = 1'b0;
    in_valid  = 2'b00;
    issue_cnt = 2'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Driver: present one fetch pair (or single) for one edge, no retire.
  task automatic drive_push(input logic [1:0] iv, input logic [31:0] pc0, input logic [31:0] pc1);
    in_valid  = iv;
    in_pc0    = pc0;
    in_inst0  = pc0 ^ MASK;
    in_pc1    = pc1;
    in_inst1  = pc1 ^ MASK;
    issue_cnt = 2'd0;
    step();
    in_valid = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", out_valid0); end
    n_checks++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %b want 0", out_valid1); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
  endtask

  task automatic test_push_pair();
    do_reset();
    drive_push(2'b11, 32'h100, 32'h104);
    n_checks++; if (count !== 4'd2) begin n_fail++; $display("FAIL push_count: got %0d want 2", count); end
    n_checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin n_fail++; $display("FAIL push_valids: got %b%b want 11", out_valid0, out_valid1); end
    n_checks++; if (out_pc0 !== 32'h100) begin n_fail++; $display("FAIL push_pc0: got %h want 100", out_pc0); end
    n_checks++; if (out_pc1 !== 32'h104) begin n_fail++; $display("FAIL push_pc1: got %h want 104", out_pc1); end
    n_checks++; if (out_inst1 !== (32'h104 ^ MASK)) begin n_fail++; $display("FAIL push_inst1: got %h want %h", out_inst1, 32'h104 ^ MASK); end
  endtask

  task automatic test_full();
    logic [31:0] exp_stall;
    do_reset();
    drive_push(2'b10, 32'hDEAD, 32'hBEEF);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL illegal_iv_count: got %0d want 0", count); end
    drive_push(2'b11, 32'h300, 32'h304);
    drive_push(2'b11, 32'h308, 32'h30C);
    drive_push(2'b11, 32'h310, 32'h314);
    n_checks++; if (count !== 4'd6 || in_ready !== 1'b1) begin n_fail++; $display("FAIL six_ready: got count %0d ready %b want 6 1", count, in_ready); end
    drive_push(2'b01, 32'h318, 32'h0);
    n_checks++; if (count !== 4'd7 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got count %0d ready %b want 7 0", count, in_ready); end
    for (int i = 0; i < 3; i++) begin
      drive_push(2'b11, 32'h900, 32'h904);
      n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_hold_count: got %0d want 7", count); end
    end
    n_checks++; if (out_pc0 !== 32'h300) begin n_fail++; $display("FAIL full_head: got %h want 300", out_pc0); end
`ifdef FQ_STATS_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    n_checks++; if (stall_cycles !== exp_stall) begin n_fail++; $display("FAIL full_stall: got %0d want %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_hold();
    do_reset();
    drive_push(2'b11, 32'h200, 32'h204);
    drive_push(2'b01, 32'h208, 32'h0);
    hold = 1'b1; issue_cnt = 2'd2;
    step();
    n_checks++; if (count !== 4'd3 || out_pc0 !== 32'h200) begin n_fail++; $display("FAIL hold_stays: got count %0d pc0 %h want 3 200", count, out_pc0); end
    hold = 1'b0;
    step();
    n_checks++; if (count !== 4'd1 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL hold_release: got count %0d v1 %b want 1 0", count, out_valid1); end
    n_checks++; if (out_pc0 !== 32'h208) begin n_fail++; $display("FAIL hold_head: got %h want 208", out_pc0); end
    issue_cnt = 2'd3;
    step();
    issue_cnt = 2'd0;
    n_checks++; if (count !== 4'd0 || out_valid0 !== 1'b0) begin n_fail++; $display("FAIL issue3_clamp: got count %0d v0 %b want 0 0", count, out_valid0); end
    issue_cnt = 2'd2;
    step();
    issue_cnt = 2'd0;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL empty_pop: got %0d want 0", count); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_push(2'b11, 32'h400, 32'h404);
    drive_push(2'b11, 32'h408, 32'h40C);
    flush = 1'b1; issue_cnt = 2'd2;
    in_valid = 2'b11; in_pc0 = 32'h777; in_pc1 = 32'h77B;
    step();
    flush = 1'b0; issue_cnt = 2'd0; in_valid = 2'b00;
    n_checks++; if (count !== 4'd0 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got count %0d v %b%b want 0 00", count, out_valid0, out_valid1); end
    drive_push(2'b01, 32'h500, 32'h0);
    n_checks++; if (count !== 4'd1 || out_pc0 !== 32'h500) begin n_fail++; $display("FAIL flush_refill: got count %0d pc0 %h want 1 500", count, out_pc0); end
  endtask

  // Scoreboard-driven: each retire compares the presented heads with exp_q.
  task automatic push_pop(input bit do_push, input int pop, inout logic [31:0] next_pc);
    for (int k = 0; k < pop; k++) begin
      if (k == 0) begin
        n_checks++; if (out_pc0 !== exp_q[0]) begin n_fail++; $display("FAIL wrap_pc0: got %h want %h", out_pc0, exp_q[0]); end
      end else begin
        n_checks++; if (out_pc1 !== exp_q[1]) begin n_fail++; $display("FAIL wrap_pc1: got %h want %h", out_pc1, exp_q[1]); end
      end
    end
    for (int k = 0; k < pop; k++) void'(exp_q.pop_front());
    in_valid = do_push ? 2'b11 : 2'b00;
    in_pc0 = next_pc; in_inst0 = next_pc ^ MASK;
    in_pc1 = next_pc + 32'd4; in_inst1 = (next_pc + 32'd4) ^ MASK;
    if (do_push) begin
      exp_q.push_back(next_pc);
      exp_q.push_back(next_pc + 32'd4);
      next_pc = next_pc + 32'd8;
    end
    issue_cnt = 2'(pop);
    step();
    in_valid = 2'b00; issue_cnt = 2'd0;
    n_checks++; if (count !== 4'(exp_q.size())) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", count, exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [31:0] next_pc;
    do_reset();
    exp_q.delete();
    next_pc = 32'h100;
    push_pop(1'b1, 0, next_pc);
    push_pop(1'b1, 0, next_pc);
    for (int i = 0; i < 4; i++) push_pop(1'b1, 2, next_pc);
    push_pop(1'b0, 2, next_pc);
    push_pop(1'b0, 2, next_pc);
    n_checks++; if (out_valid0 !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got %b want 0", out_valid0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_push(2'b11, 32'h600, 32'h604);
    drive_push(2'b11, 32'h608, 32'h60C);
    drive_push(2'b01, 32'h610, 32'h0);
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL pre_reset_count: got %0d want 5", count); end
    #3;
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin n_fail++; $display("FAIL async_valids: got %b%b want 00", out_valid0, out_valid1); end
    n_checks++; if (in_ready !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL async_ready_count: got %b %0d want 1 0", in_ready, count); end
    reset = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b0; flush = 1'b0; hold = 1'b0;
    in_valid = 2'b00; issue_cnt = 2'd0;
    in_inst0 = '0; in_pc0 = '0; in_inst1 = '0; in_pc1 = '0;
    test_reset();
    test_push_pair();
    test_full();
    test_hold();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
